// File: rtl/i2c_txn_sequencer_pkg.sv
// i2c_txn_sequencer_pkg: shared state encoding, bus-owner codes and ACK polarity.
package i2c_txn_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WWAIT, S_WBYTE, S_RBYTE, S_STOP, S_DONE
  } state_t;
  localparam logic [1:0] BUS_SEL_RELEASED = 2'd0;
  localparam logic [1:0] BUS_SEL_START    = 2'd1;
  localparam logic [1:0] BUS_SEL_BYTE     = 2'd2;
  localparam logic [1:0] BUS_SEL_STOP     = 2'd3;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: host command, data streams, engine handshakes and SDA/SCL pins.
interface i2c_txn_sequencer_if #(parameter int LEN_W = 8);
  logic             i_cmd_valid, o_cmd_ready;
  logic [6:0]       i_cmd_addr;
  logic             i_cmd_rw;
  logic [LEN_W-1:0] i_cmd_len;
  logic [7:0]       i_wr_data;
  logic             i_wr_valid, o_wr_ready;
  logic [7:0]       o_rd_data;
  logic             o_rd_valid;
  logic             o_start_req, i_start_done;
  logic             o_byte_req, o_byte_rw, o_byte_mack, i_byte_done, i_byte_sack;
  logic [7:0]       o_byte_tx, i_byte_rx;
  logic             o_stop_req, i_stop_done;
  logic [1:0]       o_bus_sel;
  logic             o_busy, o_done, o_nack;
  logic             i_start_sda, i_start_scl, i_byte_sda, i_byte_scl, i_stop_sda, i_stop_scl;
  logic             o_sda, o_scl;
  modport master (
    input  i_cmd_valid, i_cmd_addr, i_cmd_rw, i_cmd_len, i_wr_data, i_wr_valid,
           i_start_done, i_byte_done, i_byte_sack, i_byte_rx, i_stop_done,
           i_start_sda, i_start_scl, i_byte_sda, i_byte_scl, i_stop_sda, i_stop_scl,
    output o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid, o_start_req, o_byte_req,
           o_byte_rw, o_byte_mack, o_byte_tx, o_stop_req, o_bus_sel, o_busy, o_done,
           o_nack, o_sda, o_scl
  );
  modport slave (
    output i_cmd_valid, i_cmd_addr, i_cmd_rw, i_cmd_len, i_wr_data, i_wr_valid,
           i_start_done, i_byte_done, i_byte_sack, i_byte_rx, i_stop_done,
           i_start_sda, i_start_scl, i_byte_sda, i_byte_scl, i_stop_sda, i_stop_scl,
    input  o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid, o_start_req, o_byte_req,
           o_byte_rw, o_byte_mack, o_byte_tx, o_stop_req, o_bus_sel, o_busy, o_done,
           o_nack, o_sda, o_scl
  );
endinterface

// File: rtl/i2c_txn_sequencer_bus_mux.sv
// i2c_txn_sequencer_bus_mux: selects which engine owns SDA/SCL; both lines float high when released.
module i2c_txn_sequencer_bus_mux
  import i2c_txn_sequencer_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic       start_sda_i,
  input  logic       start_scl_i,
  input  logic       byte_sda_i,
  input  logic       byte_scl_i,
  input  logic       stop_sda_i,
  input  logic       stop_scl_i,
  output logic       sda_o,
  output logic       scl_o
);
  assign sda_o = sel_i == BUS_SEL_START ? start_sda_i :
                 sel_i == BUS_SEL_BYTE  ? byte_sda_i  :
                 sel_i == BUS_SEL_STOP  ? stop_sda_i  : 1'b1;
  assign scl_o = sel_i == BUS_SEL_START ? start_scl_i :
                 sel_i == BUS_SEL_BYTE  ? byte_scl_i  :
                 sel_i == BUS_SEL_STOP  ? stop_scl_i  : 1'b1;
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: runs START -> address -> N data bytes -> STOP for one host command,
// pulsing each engine once per phase and owning the SDA/SCL mux select.
module i2c_txn_sequencer
  import i2c_txn_sequencer_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input logic i_clk,
  input logic i_rst,
  i2c_txn_sequencer_if.master bus
);
  state_t           state_q;
  logic [6:0]       addr_q;
  logic             rw_q;
  logic [LEN_W-1:0] cnt_q, cnt_dec;
  logic             cmd_ready_q, wr_ready_q, start_req_q, byte_req_q, byte_rw_q, mack_q;
  logic             stop_req_q, rd_valid_q, busy_q, done_q, nack_q, to_stop;
  logic [7:0]       byte_tx_q, rd_data_q;
  logic [1:0]       bus_sel_q;
  assign cnt_dec = (cnt_q != '0) ? cnt_q - LEN_W'(1) : cnt_q;
  // Any path that ends the byte phase funnels through one STOP entry below.
  assign to_stop = bus.i_byte_done && (state_q == S_ADDR  ? (bus.i_byte_sack == NACK || cnt_q == '0) :
                                       state_q == S_WBYTE ? (bus.i_byte_sack == NACK || cnt_dec == '0) :
                                       state_q == S_RBYTE && cnt_dec == '0);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      start_req_q <= 1'b0;
      byte_req_q  <= 1'b0;
      byte_rw_q   <= 1'b0;
      mack_q      <= 1'b0;
      stop_req_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
      byte_tx_q   <= '0;
      rd_data_q   <= '0;
      bus_sel_q   <= BUS_SEL_RELEASED;
    end else begin
      start_req_q <= 1'b0;
      byte_req_q  <= 1'b0;
      stop_req_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.i_cmd_valid) begin
          addr_q      <= bus.i_cmd_addr;
          rw_q        <= bus.i_cmd_rw;
          cnt_q       <= bus.i_cmd_len;
          nack_q      <= 1'b0;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          start_req_q <= 1'b1;
          bus_sel_q   <= BUS_SEL_START;
          state_q     <= S_START;
        end
        S_START: if (bus.i_start_done) begin
          byte_tx_q  <= {addr_q, rw_q};
          byte_rw_q  <= 1'b0;
          byte_req_q <= 1'b1;
          bus_sel_q  <= BUS_SEL_BYTE;
          state_q    <= S_ADDR;
        end
        S_ADDR: if (bus.i_byte_done) begin
          wr_ready_q <= !rw_q;
          byte_req_q <= rw_q;
          byte_rw_q  <= rw_q;
          mack_q     <= rw_q && cnt_q == LEN_W'(1);
          state_q    <= rw_q ? S_RBYTE : S_WWAIT;
        end
        S_WWAIT: if (bus.i_wr_valid) begin
          byte_tx_q  <= bus.i_wr_data;
          byte_req_q <= 1'b1;
          wr_ready_q <= 1'b0;
          state_q    <= S_WBYTE;
        end
        S_WBYTE: if (bus.i_byte_done) begin
          cnt_q      <= cnt_dec;
          wr_ready_q <= 1'b1;
          state_q    <= S_WWAIT;
        end
        S_RBYTE: if (bus.i_byte_done) begin
          cnt_q      <= cnt_dec;
          rd_data_q  <= bus.i_byte_rx;
          rd_valid_q <= 1'b1;
          byte_req_q <= 1'b1;
          mack_q     <= cnt_dec == LEN_W'(1);
        end
        S_STOP: if (bus.i_stop_done) begin
          done_q    <= 1'b1;
          bus_sel_q <= BUS_SEL_RELEASED;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
      if (to_stop) begin
        nack_q     <= nack_q | (bus.i_byte_sack == NACK && state_q != S_RBYTE);
        wr_ready_q <= 1'b0;
        byte_req_q <= 1'b0;
        byte_rw_q  <= 1'b0;
        mack_q     <= 1'b0;
        stop_req_q <= 1'b1;
        bus_sel_q  <= BUS_SEL_STOP;
        state_q    <= S_STOP;
      end
    end
  end
  assign bus.o_cmd_ready = cmd_ready_q;
  assign bus.o_wr_ready  = wr_ready_q;
  assign bus.o_rd_data   = rd_data_q;
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_start_req = start_req_q;
  assign bus.o_byte_req  = byte_req_q;
  assign bus.o_byte_rw   = byte_rw_q;
  assign bus.o_byte_tx   = byte_tx_q;
  assign bus.o_byte_mack = mack_q;
  assign bus.o_stop_req  = stop_req_q;
  assign bus.o_bus_sel   = bus_sel_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_nack      = nack_q;
  i2c_txn_sequencer_bus_mux u_mux (
    .sel_i       (bus_sel_q),
    .start_sda_i (bus.i_start_sda),
    .start_scl_i (bus.i_start_scl),
    .byte_sda_i  (bus.i_byte_sda),
    .byte_scl_i  (bus.i_byte_scl),
    .stop_sda_i  (bus.i_stop_sda),
    .stop_scl_i  (bus.i_stop_scl),
    .sda_o       (bus.o_sda),
    .scl_o       (bus.o_scl)
  );
endmodule
